// File: rtl/tlp_mwr_axi_write_master_pkg.sv
// Shared constants and state types for the TLP memory-write to AXI4 write master.
package tlp_axi_pkg;

  localparam logic [6:0] FMT_MWR_3DW     = 7'b1000000;
  localparam logic [6:0] FMT_MWR_4DW     = 7'b1100000;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_DROP
  } rx_state_t;

  typedef enum logic {
    SP_IDLE,
    SP_AW
  } sp_state_t;

  function automatic logic is_mwr(input logic [6:0] fmt_type);
    return (fmt_type == FMT_MWR_3DW) || (fmt_type == FMT_MWR_4DW);
  endfunction

endpackage

// File: rtl/tlp_mwr_axi_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the write master and its slave.
interface tlp_mwr_axi_write_master_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/pcie_sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest entry while !empty.
module pcie_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; payload needs no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tlp_mwr_axi_write_master.sv
// Converts posted MWr TLPs into AXI4 INCR write bursts; drops all other TLP types.
module tlp_mwr_axi_write_master
  import tlp_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int DATA_FIFO_DEPTH = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tlp_in_valid,
  input  logic [6:0]  tlp_in_fmt_type,
  input  logic [31:0] tlp_in_address,
  input  logic [10:0] tlp_in_length_in_dw,
  input  logic [1:0]  tlp_in_attr,
  input  logic [23:0] tlp_in_transaction_id,
  input  logic [12:0] tlp_in_byte_count,
  input  logic [31:0] tlp_in_data,
  input  logic [3:0]  tlp_in_byte_en,
  output logic        tlp_in_accept_data,
  tlp_mwr_axi_write_master_if.master axi,
  input  logic        err_clr,
  output logic        wr_err,
  output logic        tlp_drop,
  output logic        idle
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  rx_state_t           rx_state, rx_next;
  sp_state_t           sp_state, sp_next;
  logic [10:0]         rx_rem;
  logic [10:0]         hdr_len;
  logic                hdr_mwr;
  logic                beat;
  logic                first_beat;
  logic                data_push, data_full, data_empty;
  logic [35:0]         data_dout;
  logic                len_empty, len_full, len_pop;
  logic [7:0]          len_dout;
  logic [AXI_ADDR_WIDTH-1:0] sp_addr;
  logic [10:0]         sp_rem;
  logic [10:0]         burst_beats;
  logic                aw_hs, w_hs, b_hs;
  logic                w_active;
  logic [7:0]          w_cnt;
  logic [OW-1:0]       outstanding;
  logic                unused_fields;

  // Header fields that carry no meaning for a posted write.
  assign unused_fields = ^{tlp_in_attr, tlp_in_transaction_id, tlp_in_byte_count, len_full};

  assign hdr_len    = (tlp_in_length_in_dw == 11'd0) ? 11'd1024 : tlp_in_length_in_dw;
  assign hdr_mwr    = is_mwr(tlp_in_fmt_type);
  assign beat       = tlp_in_valid && tlp_in_accept_data;
  assign first_beat = beat && (rx_state == RX_IDLE);
  assign tlp_drop   = first_beat && !hdr_mwr;
  assign data_push  = beat && ((rx_state == RX_DATA) || ((rx_state == RX_IDLE) && hdr_mwr));

  // Beat acceptance: a new TLP waits for the splitter to finish the previous one.
  always_comb begin
    tlp_in_accept_data = 1'b0;
    if (!reset) begin
      case (rx_state)
        RX_DROP: tlp_in_accept_data = 1'b1;
        RX_DATA: tlp_in_accept_data = !data_full;
        default: tlp_in_accept_data = !data_full && (sp_state == SP_IDLE);
      endcase
    end
  end

  // RX next state: single-DW TLPs never leave RX_IDLE.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (beat && (hdr_len != 11'd1)) rx_next = hdr_mwr ? RX_DATA : RX_DROP;
      RX_DATA,
      RX_DROP: if (beat && (rx_rem == 11'd1)) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // RX state register and remaining-beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_rem   <= '0;
    end else begin
      rx_state <= rx_next;
      if (first_beat)  rx_rem <= hdr_len - 11'd1;
      else if (beat)   rx_rem <= rx_rem - 11'd1;
    end
  end

  pcie_sync_fifo #(.WIDTH(36), .DEPTH(DATA_FIFO_DEPTH)) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_push),
    .din   ({tlp_in_byte_en, tlp_in_data}),
    .pop   (w_hs),
    .dout  (data_dout),
    .full  (data_full),
    .empty (data_empty)
  );

  assign burst_beats = (sp_rem > 11'(MAX_BURST_LEN)) ? 11'(MAX_BURST_LEN) : sp_rem;
  assign aw_hs       = axi.awvalid && axi.awready;

  assign axi.awaddr  = sp_addr;
  assign axi.awlen   = 8'(burst_beats - 11'd1);
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  // Outstanding never rises while awvalid is high, so awvalid cannot drop before awready.
  assign axi.awvalid = (sp_state == SP_AW) && (outstanding != OW'(MAX_OUTSTANDING));

  // Splitter next state: one AW per burst until the TLP length is exhausted.
  always_comb begin
    sp_next = sp_state;
    case (sp_state)
      SP_IDLE: if (first_beat && hdr_mwr) sp_next = SP_AW;
      SP_AW:   if (aw_hs && (sp_rem == burst_beats)) sp_next = SP_IDLE;
      default: sp_next = SP_IDLE;
    endcase
  end

  // Splitter state and remaining DW count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_state <= SP_IDLE;
      sp_rem   <= '0;
    end else begin
      sp_state <= sp_next;
      if (first_beat && hdr_mwr) sp_rem <= hdr_len;
      else if (aw_hs)            sp_rem <= sp_rem - burst_beats;
    end
  end

  // Burst address; advances by 4 bytes per beat and wraps at the AXI address width.
  always_ff @(posedge clk) begin
    if (first_beat && hdr_mwr) sp_addr <= AXI_ADDR_WIDTH'(tlp_in_address);
    else if (aw_hs)            sp_addr <= sp_addr + AXI_ADDR_WIDTH'({burst_beats, 2'b00});
  end

  pcie_sync_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_len_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (aw_hs),
    .din   (axi.awlen),
    .pop   (len_pop),
    .dout  (len_dout),
    .full  (len_full),
    .empty (len_empty)
  );

  assign len_pop    = !w_active && !len_empty;
  assign axi.wvalid = w_active && !data_empty;
  assign axi.wlast  = w_active && (w_cnt == 8'd0);
  assign axi.wdata  = data_dout[31:0];
  assign axi.wstrb  = data_dout[35:32];
  assign w_hs       = axi.wvalid && axi.wready;

  // W engine: take one burst length, then count its beats down to wlast.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_active <= 1'b0;
      w_cnt    <= '0;
    end else if (len_pop) begin
      w_active <= 1'b1;
      w_cnt    <= len_dout;
    end else if (w_hs) begin
      if (w_cnt == 8'd0) w_active <= 1'b0;
      else               w_cnt    <= w_cnt - 8'd1;
    end
  end

  assign axi.bready = 1'b1;
  assign b_hs       = axi.bvalid && axi.bready;

  // Bursts in flight: issued AW without a returned B.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)                                   wr_err <= 1'b0;
    else if (b_hs && (axi.bresp != AXI_RESP_OKAY)) wr_err <= 1'b1;
    else if (err_clr)                            wr_err <= 1'b0;
  end

  assign idle = (rx_state == RX_IDLE) && (sp_state == SP_IDLE) && data_empty &&
                len_empty && !w_active && (outstanding == '0);

endmodule

// File: tb/tb_tlp_mwr_axi_write_master.sv
// Directed bench for the TLP MWr to AXI write master with a simple AXI slave model.
`timescale 1ns/1ps
module tb_tlp_mwr_axi_write_master;
  import tlp_axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tlp_valid;
  logic [6:0]  tlp_fmt;
  logic [31:0] tlp_addr;
  logic [10:0] tlp_len;
  logic [1:0]  tlp_attr;
  logic [23:0] tlp_tid;
  logic [12:0] tlp_bc;
  logic [31:0] tlp_data;
  logic [3:0]  tlp_be;
  logic        accept;
  logic        err_clr;
  logic        wr_err;
  logic        tlp_drop;
  logic        idle;
  logic [1:0]  bresp_cfg;

  always #5 clk = ~clk;

  tlp_mwr_axi_write_master_if #(.ADDR_W(32)) axi ();

  tlp_mwr_axi_write_master #(
    .AXI_ADDR_WIDTH(32), .MAX_BURST_LEN(16), .DATA_FIFO_DEPTH(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .tlp_in_valid          (tlp_valid),
    .tlp_in_fmt_type       (tlp_fmt),
    .tlp_in_address        (tlp_addr),
    .tlp_in_length_in_dw   (tlp_len),
    .tlp_in_attr           (tlp_attr),
    .tlp_in_transaction_id (tlp_tid),
    .tlp_in_byte_count     (tlp_bc),
    .tlp_in_data           (tlp_data),
    .tlp_in_byte_en        (tlp_be),
    .tlp_in_accept_data    (accept),
    .axi                   (axi),
    .err_clr               (err_clr),
    .wr_err                (wr_err),
    .tlp_drop              (tlp_drop),
    .idle                  (idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] w_data_q[$];
  logic [3:0]  w_strb_q[$];
  logic        w_last_q[$];
  int          acc_cnt = 0;
  int          drop_cnt = 0;
  int          b_pending = 0;

  // Slave-side monitor: records handshakes that complete at the following rising edge.
  always @(negedge clk) begin
    if (reset) begin
      b_pending <= 0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        aw_addr_q.push_back(axi.awaddr);
        aw_len_q.push_back(axi.awlen);
      end
      if (axi.wvalid && axi.wready) begin
        w_data_q.push_back(axi.wdata);
        w_strb_q.push_back(axi.wstrb);
        w_last_q.push_back(axi.wlast);
      end
      b_pending <= b_pending + ((axi.wvalid && axi.wready && axi.wlast) ? 1 : 0)
                             - ((axi.bvalid && axi.bready) ? 1 : 0);
      if (tlp_valid && accept) acc_cnt <= acc_cnt + 1;
      if (tlp_drop)            drop_cnt <= drop_cnt + 1;
    end
  end

  // B responder: one response per completed burst.
  initial begin
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      axi.bvalid = (b_pending > 0) && !reset;
      axi.bresp  = bresp_cfg;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    aw_addr_q.delete();
    aw_len_q.delete();
    w_data_q.delete();
    w_strb_q.delete();
    w_last_q.delete();
  endtask

  task automatic send_tlp(input logic [6:0] fmt, input logic [31:0] addr, input int len,
                          input logic [31:0] d0, input logic [31:0] step);
    for (int i = 0; i < len; i++) begin
      int t = 0;
      tlp_valid = 1'b1;
      tlp_fmt   = fmt;
      tlp_addr  = addr;
      tlp_len   = 11'(len);
      tlp_data  = d0 + 32'(i) * step;
      tlp_be    = 4'hF;
      @(negedge clk);
      while (!accept && t < 2000) begin
        t++;
        @(negedge clk);
      end
      if (t >= 2000) check("accept_timeout", 64'(t), 64'(0));
      @(posedge clk);
      #1;
    end
    tlp_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t = 0;
    @(negedge clk);
    while (!idle && t < limit) begin
      t++;
      @(negedge clk);
    end
    check(tag, 64'(t < limit), 64'(1));
    @(posedge clk);
    #1;
  endtask

  int acc0;
  int drop0;
  int bad;
  int nlast;
  int t3_done;

  initial begin
    tlp_valid = 1'b0; tlp_fmt = '0; tlp_addr = '0; tlp_len = '0;
    tlp_attr = 2'b01; tlp_tid = 24'h123456; tlp_bc = 13'h10;
    tlp_data = '0; tlp_be = 4'hF; err_clr = 1'b0; bresp_cfg = AXI_RESP_OKAY;
    axi.awready = 1'b1; axi.wready = 1'b1;
    t3_done = 0;
    repeat (3) @(posedge clk);

    // Reset values
    @(negedge clk);
    check("rst_awvalid", 64'(axi.awvalid), 64'(0));
    check("rst_wvalid", 64'(axi.wvalid), 64'(0));
    check("rst_wlast", 64'(axi.wlast), 64'(0));
    check("rst_wr_err", 64'(wr_err), 64'(0));
    check("rst_tlp_drop", 64'(tlp_drop), 64'(0));
    check("rst_accept", 64'(accept), 64'(0));
    check("rst_bready", 64'(axi.bready), 64'(1));
    check("rst_idle", 64'(idle), 64'(1));
    @(posedge clk);
    #1 reset = 1'b0;

    // Single 4-DW burst
    clear_mon();
    send_tlp(FMT_MWR_3DW, 32'h0, 4, 32'd10, 32'd10);
    wait_idle("t1_idle", 300);
    check("t1_aw_cnt", 64'(aw_addr_q.size()), 64'(1));
    check("t1_awaddr", 64'(aw_addr_q[0]), 64'h0);
    check("t1_awlen", 64'(aw_len_q[0]), 64'(3));
    check("t1_awsize", 64'(axi.awsize), 64'(3'b010));
    check("t1_awburst", 64'(axi.awburst), 64'(2'b01));
    check("t1_w_cnt", 64'(w_data_q.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_wdata%0d", i), 64'(w_data_q[i]), 64'(10 * (i + 1)));
      check($sformatf("t1_wstrb%0d", i), 64'(w_strb_q[i]), 64'hF);
      check($sformatf("t1_wlast%0d", i), 64'(w_last_q[i]), 64'(i == 3));
    end

    // 20 DWs split into 16 + 4
    clear_mon();
    send_tlp(FMT_MWR_4DW, 32'h100, 20, 32'h1000, 32'd1);
    wait_idle("t2_idle", 300);
    check("t2_aw_cnt", 64'(aw_addr_q.size()), 64'(2));
    check("t2_awaddr0", 64'(aw_addr_q[0]), 64'h100);
    check("t2_awlen0", 64'(aw_len_q[0]), 64'(15));
    check("t2_awaddr1", 64'(aw_addr_q[1]), 64'h140);
    check("t2_awlen1", 64'(aw_len_q[1]), 64'(3));
    check("t2_w_cnt", 64'(w_data_q.size()), 64'(20));
    bad = 0;
    nlast = 0;
    for (int i = 0; i < w_data_q.size(); i++) begin
      if (w_data_q[i] !== 32'h1000 + 32'(i)) bad++;
      if (w_last_q[i]) nlast++;
    end
    check("t2_wdata_order", 64'(bad), 64'(0));
    check("t2_nlast", 64'(nlast), 64'(2));
    check("t2_wlast15", 64'(w_last_q[15]), 64'(1));
    check("t2_wlast19", 64'(w_last_q[19]), 64'(1));

    // Backpressure: FIFO fills to its depth, then drains in order
    clear_mon();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send_tlp(FMT_MWR_3DW, 32'h200, 100, 32'hC000, 32'd1);
        t3_done = 1;
      end
    join_none
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("t3_accepted", 64'(acc_cnt - acc0), 64'(64));
    check("t3_accept_low", 64'(accept), 64'(0));
    check("t3_no_aw", 64'(aw_addr_q.size()), 64'(0));
    @(posedge clk);
    #1;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    for (int t = 0; t < 3000 && t3_done == 0; t++) @(posedge clk);
    #1;
    check("t3_send_done", 64'(t3_done), 64'(1));
    wait_idle("t3_idle", 500);
    check("t3_total_acc", 64'(acc_cnt - acc0), 64'(100));
    check("t3_aw_cnt", 64'(aw_addr_q.size()), 64'(7));
    check("t3_awaddr_last", 64'(aw_addr_q[6]), 64'h380);
    check("t3_awlen_last", 64'(aw_len_q[6]), 64'(3));
    check("t3_w_cnt", 64'(w_data_q.size()), 64'(100));
    bad = 0;
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'hC000 + 32'(i)) bad++;
    check("t3_wdata_order", 64'(bad), 64'(0));

    // Error response is sticky until cleared
    clear_mon();
    bresp_cfg = AXI_RESP_SLVERR;
    send_tlp(FMT_MWR_3DW, 32'h300, 1, 32'hDEAD, 32'd0);
    wait_idle("t4_idle_a", 200);
    check("t4_awlen", 64'(aw_len_q[0]), 64'(0));
    check("t4_wlast", 64'(w_last_q[0]), 64'(1));
    check("t4_err_set", 64'(wr_err), 64'(1));
    bresp_cfg = AXI_RESP_OKAY;
    send_tlp(FMT_MWR_3DW, 32'h310, 2, 32'hBEEF, 32'd1);
    wait_idle("t4_idle_b", 200);
    check("t4_err_sticky", 64'(wr_err), 64'(1));
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("t4_err_clr", 64'(wr_err), 64'(0));
    @(posedge clk);
    #1;

    // Non-MWr TLP is dropped; the next MWr still goes through
    clear_mon();
    drop0 = drop_cnt;
    acc0  = acc_cnt;
    send_tlp(7'b0000000, 32'h400, 2, 32'h77, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t5_drop_pulses", 64'(drop_cnt - drop0), 64'(1));
    check("t5_drop_acc", 64'(acc_cnt - acc0), 64'(2));
    check("t5_no_aw", 64'(aw_addr_q.size()), 64'(0));
    check("t5_no_w", 64'(w_data_q.size()), 64'(0));
    send_tlp(FMT_MWR_3DW, 32'h40, 2, 32'h55, 32'd1);
    wait_idle("t5_idle", 200);
    check("t5_awaddr", 64'(aw_addr_q[0]), 64'h40);
    check("t5_awlen", 64'(aw_len_q[0]), 64'(1));
    check("t5_w_cnt", 64'(w_data_q.size()), 64'(2));
    check("t5_wdata1", 64'(w_data_q[1]), 64'h56);
    check("t5_wlast1", 64'(w_last_q[1]), 64'(1));
    check("t5_no_new_drop", 64'(drop_cnt - drop0), 64'(1));

    // Reset in the middle of a burst
    clear_mon();
    axi.wready = 1'b0;
    send_tlp(FMT_MWR_3DW, 32'h800, 16, 32'h800, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("t6_aw_cnt", 64'(aw_addr_q.size()), 64'(1));
    axi.wready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    axi.wready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_w_beats", 64'(w_data_q.size()), 64'(3));
    check("t6_awvalid", 64'(axi.awvalid), 64'(0));
    check("t6_wvalid", 64'(axi.wvalid), 64'(0));
    check("t6_idle", 64'(idle), 64'(1));
    @(posedge clk);
    #1;
    axi.wready = 1'b1;
    clear_mon();
    send_tlp(FMT_MWR_3DW, 32'h900, 4, 32'hA0, 32'd1);
    wait_idle("t6_idle_after", 200);
    check("t6_aw_cnt2", 64'(aw_addr_q.size()), 64'(1));
    check("t6_awaddr", 64'(aw_addr_q[0]), 64'h900);
    check("t6_awlen", 64'(aw_len_q[0]), 64'(3));
    check("t6_w_cnt", 64'(w_data_q.size()), 64'(4));
    check("t6_wdata0", 64'(w_data_q[0]), 64'hA0);
    check("t6_wdata3", 64'(w_data_q[3]), 64'hA3);
    check("t6_wlast3", 64'(w_last_q[3]), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
